// File: rtl/cic_pkg.sv
// cic_pkg: shared constants and helpers for the multi-channel CIC decimator
package cic_pkg;
   localparam int RMIN = 2;
   localparam int MAXW = 128;

   // ceil(log2(v)) for sizing counters and fields
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // arithmetic right shift followed by clamping to a signed range of the given bit width
   function automatic logic signed [MAXW-1:0] sat_shift(
      input  logic signed [MAXW-1:0] v,
      input  int                     sh,
      input  int                     bits,
      output logic                   sat
   );
      logic signed [MAXW-1:0] y, hi, lo;
      y   = v >>> sh;
      hi  = (MAXW'(1) << (bits - 1)) - MAXW'(1);
      lo  = ~hi;
      sat = (y > hi) || (y < lo);
      return (y > hi) ? hi : ((y < lo) ? lo : y);
   endfunction
endpackage

// File: rtl/cic_chan.sv
// cic_chan: one channel's integrators, frame capture, comb pipeline and output scaler
module cic_chan
   import cic_pkg::*;
#(
   parameter int NSTAGES    = 5,
   parameter int WIDTH      = 76,
   parameter int BITS       = 16,
   parameter int SHIFT_BITS = 7
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_in_valid,
   input  logic signed [BITS-1:0] i_x,
   input  logic                   i_cap,
   input  logic [NSTAGES:0]       i_vld,
   input  logic [SHIFT_BITS-1:0]  i_shift,
   output logic signed [BITS-1:0] o_y,
   output logic                   o_sat
);
   logic signed [WIDTH-1:0] r_int [NSTAGES];
   logic signed [WIDTH-1:0] r_cap;
   logic signed [WIDTH-1:0] r_del [NSTAGES];
   logic signed [WIDTH-1:0] r_cmb [NSTAGES];
   logic signed [WIDTH-1:0] w_cin [NSTAGES];
   logic signed [BITS-1:0]  w_y;
   logic                    w_sat;

   // integrator chain: each stage adds its predecessor's old value on every accepted sample
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int s = 0; s < NSTAGES; s++) r_int[s] <= '0;
      end else if (i_in_valid) begin
         r_int[0] <= r_int[0] + WIDTH'(i_x);
         for (int s = 1; s < NSTAGES; s++) r_int[s] <= r_int[s] + r_int[s-1];
      end
   end

   // comb inputs: the first stage reads the captured integrator, later stages the previous comb
   always_comb begin
      w_cin[0] = r_cap;
      for (int s = 1; s < NSTAGES; s++) w_cin[s] = r_cmb[s-1];
   end

   // capture I_N at the frame boundary; each comb stage fires when its valid tag reaches it
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cap <= '0;
         for (int s = 0; s < NSTAGES; s++) begin
            r_del[s] <= '0;
            r_cmb[s] <= '0;
         end
      end else begin
         if (i_cap) r_cap <= r_int[NSTAGES-1];
         for (int s = 0; s < NSTAGES; s++) begin
            if (i_vld[s]) begin
               r_cmb[s] <= w_cin[s] - r_del[s];
               r_del[s] <= w_cin[s];
            end
         end
      end
   end

   // scale the last comb output and clamp it to the sample range
   always_comb begin
      w_sat = 1'b0;
      w_y   = BITS'(sat_shift(MAXW'(r_cmb[NSTAGES-1]), int'(i_shift), BITS, w_sat));
   end

   assign o_sat = i_vld[NSTAGES] & w_sat;

   // output register loads on the final valid tag and holds between ticks
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) o_y <= '0;
      else if (i_vld[NSTAGES]) o_y <= w_y;
   end
endmodule

// File: rtl/cic_decim_mc.sv
// cic_decim_mc: multi-channel CIC decimator with shared rate counter, runtime rate/shift and sticky overflow
module cic_decim_mc
   import cic_pkg::*;
#(
   parameter int NSTAGES    = 5,
   parameter int WIDTH      = 76,
   parameter int BITS       = 16,
   parameter int NCH        = 2,
   parameter int RATE_BITS  = 12,
   parameter int SHIFT_BITS = 7
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_in_valid,
   input  logic [NCH*BITS-1:0]   i_x_in,
   input  logic [RATE_BITS-1:0]  i_decim,
   input  logic [SHIFT_BITS-1:0] i_shift,
   input  logic                  i_clr_ovf,
   output logic [NCH*BITS-1:0]   o_x_out,
   output logic                  o_out_tick,
   output logic                  o_overflow
);
   logic [RATE_BITS-1:0]  r_cnt, r_r_q, w_rate;
   logic [SHIFT_BITS-1:0] r_s_q;
   logic [NSTAGES:0]      r_vld;
   logic [NCH-1:0]        w_sat;
   logic                  w_cap;

   generate
      if (WIDTH < BITS + NSTAGES * RATE_BITS || NSTAGES < 1 || NSTAGES > 8 || WIDTH > MAXW) begin : g_param_err
         $error("cic_decim_mc: accumulator too narrow or stage count out of range");
      end
   endgenerate

   assign w_rate = (i_decim < RATE_BITS'(RMIN)) ? RATE_BITS'(RMIN) : i_decim;
   assign w_cap  = i_in_valid && (r_cnt == r_r_q - RATE_BITS'(1));

   // shared rate counter, frame-boundary reload of rate/shift, valid-tag chain and sticky overflow
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_r_q      <= w_rate;
         r_s_q      <= i_shift;
         r_vld      <= '0;
         o_out_tick <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         if (i_in_valid) r_cnt <= w_cap ? '0 : r_cnt + RATE_BITS'(1);
         if (w_cap) begin
            r_r_q <= w_rate;
            r_s_q <= i_shift;
         end
         r_vld      <= {r_vld[NSTAGES-1:0], w_cap};
         o_out_tick <= r_vld[NSTAGES];
         o_overflow <= (|w_sat) | (o_overflow & ~i_clr_ovf);
      end
   end

   genvar c;
   for (c = 0; c < NCH; c++) begin : g_ch
      cic_chan #(
         .NSTAGES   (NSTAGES),
         .WIDTH     (WIDTH),
         .BITS      (BITS),
         .SHIFT_BITS(SHIFT_BITS)
      ) u_ch (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_in_valid(i_in_valid),
         .i_x       (i_x_in[c*BITS +: BITS]),
         .i_cap     (w_cap),
         .i_vld     (r_vld),
         .i_shift   (r_s_q),
         .o_y       (o_x_out[c*BITS +: BITS]),
         .o_sat     (w_sat[c])
      );
   end
endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc: directed checks of the CIC decimator (DC gain, saturation, shift, rate change, gaps, reset)
module tb_cic_decim_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_valid = 1'b0;
   logic        gap = 1'b0;
   logic        in_valid;
   logic [31:0] x_in = '0;
   logic [11:0] decim = 12'd4;
   logic [6:0]  shift = '0;
   logic        clr = 1'b0;
   logic [31:0] x_out;
   logic        tick, ovf;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          imp [6] = '{0, 15, 135, 101, 5, 0};
   int          sp [4] = '{4, 4, 8, 8};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign in_valid = en_valid & (~gap | (cyc % 3 == 0));

   cic_decim_mc dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_in_valid(in_valid),
      .i_x_in    (x_in),
      .i_decim   (decim),
      .i_shift   (shift),
      .i_clr_ovf (clr),
      .o_x_out   (x_out),
      .o_out_tick(tick),
      .o_overflow(ovf)
   );

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_x(input int a, input int b);
      x_in = {16'(b), 16'(a)};
   endtask

   task automatic do_rst(input int d, input int s);
      en_valid = 1'b0;
      gap      = 1'b0;
      clr      = 1'b0;
      x_in     = '0;
      decim    = 12'(d);
      shift    = 7'(s);
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_tick(output logic signed [15:0] a, output logic signed [15:0] b, output int t);
      bit got;
      got = 1'b0;
      a = '0;
      b = '0;
      t = cyc;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (tick) begin
            got = 1'b1;
            a = x_out[15:0];
            b = x_out[31:16];
            t = cyc;
         end
      end
      if (!got) chk("tick_timeout", 0, 1);
   endtask

   task automatic skip(input int n);
      logic signed [15:0] a, b;
      int t;
      repeat (n) wait_tick(a, b, t);
   endtask

   initial begin
      logic signed [15:0] a, b;
      int t, tp, c0, v1, n;

      do_rst(4, 0);
      chk("rst_xout", x_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_ovf", ovf, 0);

      set_x(1, 1);
      c0 = cyc;
      en_valid = 1'b1;
      wait_tick(a, b, t);
      chk("dc_latency", t, c0 + 10);
      tp = t;
      for (int j = 1; j <= 8; j++) begin
         wait_tick(a, b, t);
         chk("dc_spacing", t - tp, 4);
         tp = t;
         if (j >= 5) begin
            chk("dc_ch0", a, 1024);
            chk("dc_ch1", b, 1024);
         end
      end
      chk("dc_ovf", ovf, 0);

      do_rst(4, 0);
      set_x(100, 100);
      en_valid = 1'b1;
      skip(10);
      wait_tick(a, b, t);
      chk("sat_pos_ch0", a, 32767);
      chk("sat_pos_ch1", b, 32767);
      chk("sat_pos_ovf", ovf, 1);
      set_x(1, 1);
      skip(10);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("ovf_clear", ovf, 0);
      skip(3);
      wait_tick(a, b, t);
      chk("clr_value", a, 1024);
      chk("ovf_stays_clear", ovf, 0);
      set_x(-100, -100);
      skip(10);
      wait_tick(a, b, t);
      chk("sat_neg_ch0", a, -32768);
      chk("sat_neg_ch1", b, -32768);
      chk("sat_neg_ovf", ovf, 1);

      do_rst(4, 10);
      set_x(100, -37);
      en_valid = 1'b1;
      skip(10);
      for (int j = 0; j < 2; j++) begin
         wait_tick(a, b, t);
         chk("shift_ch0", a, 100);
         chk("shift_ch1", b, -37);
      end
      chk("shift_ovf", ovf, 0);

      do_rst(4, 0);
      set_x(1, 1);
      en_valid = 1'b1;
      skip(6);
      wait_tick(a, b, tp);
      decim = 12'd8;
      for (int j = 0; j < 4; j++) begin
         wait_tick(a, b, t);
         chk("rate_spacing", t - tp, sp[j]);
         tp = t;
      end
      skip(10);
      wait_tick(a, b, t);
      chk("rate8_ch0", a, 32767);
      chk("rate8_ch1", b, 32767);
      chk("rate8_ovf", ovf, 1);

      do_rst(4, 0);
      set_x(1, 1);
      gap = 1'b1;
      c0 = cyc;
      v1 = c0 + (3 - c0 % 3) % 3;
      en_valid = 1'b1;
      wait_tick(a, b, t);
      chk("gap_latency", t, v1 + 16);
      tp = t;
      for (int j = 1; j <= 8; j++) begin
         wait_tick(a, b, t);
         chk("gap_spacing", t - tp, 12);
         tp = t;
         if (j >= 5) begin
            chk("gap_ch0", a, 1024);
            chk("gap_ch1", b, 1024);
         end
      end

      do_rst(4, 0);
      set_x(100, 100);
      en_valid = 1'b1;
      skip(10);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_xout", x_out, 0);
      chk("arst_tick", tick, 0);
      chk("arst_ovf", ovf, 0);
      en_valid = 1'b0;
      set_x(0, 0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (tick) n++;
      end
      chk("arst_no_tick", n, 0);
      set_x(1, 1);
      en_valid = 1'b1;
      @(negedge clk);
      set_x(0, 0);
      for (int j = 0; j < 6; j++) begin
         wait_tick(a, b, t);
         chk("impulse_ch0", a, imp[j]);
         chk("impulse_ch1", b, imp[j]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end
endmodule
